// File: rtl/xor_encrypt_packer.sv
// Packs a 32-bit valid/ready word stream into zero-padded blocks for xor_encrypt.
// Each finished block is presented on code/key with a one-cycle valid_out strobe.
module packer_lane #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] stage_word,
    input  logic [WORD_W-1:0] in_data,
    input  logic              sel,
    input  logic              keep,
    output logic [WORD_W-1:0] word
);
    always_comb begin
        word = '0;
        if (sel)       word = in_data;
        else if (keep) word = stage_word;
    end
endmodule

module xor_encrypt_packer #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 256,
    parameter int KEY_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    output logic [BLOCK_W-1:0] code,
    output logic [KEY_W-1:0]   key,
    output logic               valid_out,
    output logic [3:0]         pad_words,
    output logic [15:0]        blk_cnt
);
    localparam int WORDS = BLOCK_W / WORD_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [3:0]       PAD_MAX  = 4'(WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                        state, state_nxt;
    logic [IDX_W-1:0]              idx, idx_nxt;
    logic [KEY_W-1:0]              key_stage;
    logic [WORDS-1:0][WORD_W-1:0]  stage;
    logic [WORDS-1:0][WORD_W-1:0]  merged;
    logic [WORDS-1:0]              sel, keep;
    logic                          accept, done;

    assign in_ready = en;
    assign accept   = in_valid && en;
    assign done     = accept && (idx == LAST_IDX || in_last);

    for (genvar w = 0; w < WORDS; w++) begin : g_sel
        assign sel[w]  = (idx == IDX_W'(w));
        assign keep[w] = (IDX_W'(w) < idx);
    end

    // Merged view: staged words below idx, the incoming word at idx, zeros above.
    packer_lane #(.WORD_W(WORD_W)) u_lane [WORDS-1:0] (
        .stage_word (stage),
        .in_data    (in_data),
        .sel        (sel),
        .keep       (keep),
        .word       (merged)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (done) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else if (accept) begin
            state_nxt = FILL;
            idx_nxt   = idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage     <= '0;
            key_stage <= '0;
        end else if (done) begin
            stage <= '0;
        end else if (accept) begin
            stage[idx] <= in_data;
            if (state == IDLE) key_stage <= key_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code      <= '0;
            key       <= '0;
            valid_out <= 1'b0;
            pad_words <= '0;
            blk_cnt   <= '0;
        end else begin
            valid_out <= done;
            if (done) begin
                code      <= merged;
                // A single-word block never latched key_stage, so take key_in directly.
                key       <= (state == IDLE) ? key_in : key_stage;
                pad_words <= PAD_MAX - 4'(idx);
                blk_cnt   <= blk_cnt + 16'd1;
            end
        end
    end
endmodule

// File: doc/xor_encrypt_packer.md
Name: xor_encrypt_packer

Overview:
- Upstream feeder for xor_encrypt. Packs a 32-bit word stream (valid/ready) into 256-bit blocks.
- Each block goes out with the 8-bit key captured at the block's first word, plus a one-cycle valid pulse.
- Drives xor_encrypt's code/key/valid_in directly; xor_encrypt has no backpressure, so valid_out is a strobe and code/key hold until the next block.
- Short final blocks (in_last before 8 words) are zero-padded.

Parameters:
- WORD_W, 32, input word width in bits.
- BLOCK_W, 256, output block width in bits; must be an integer multiple of WORD_W.
- KEY_W, 8, key width in bits.
- WORDS, BLOCK_W/WORD_W (8), words per block; derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  packer enable; in_ready = en
- key_in  in  KEY_W  key; sampled only on a block's first accepted word
- in_valid  in  1  input word valid
- in_ready  out  1  input ready (combinational, = en)
- in_data  in  WORD_W  input word
- in_last  in  1  marks final word of a message; closes the current block
- code  out  BLOCK_W  packed block to xor_encrypt
- key  out  KEY_W  key for the block on code
- valid_out  out  1  one-cycle strobe; code/key valid when high
- pad_words  out  4  count of zero-padded words in the block on code (0..7)
- blk_cnt  out  16  number of blocks emitted since reset, wrapping

Behaviour:
- Handshake: a word is accepted when in_valid && in_ready.
  - en low: in_ready low, nothing accepted, internal fill state frozen.
  - A partially filled block survives en low/high toggles intact.
- Reset (rst_n low, async, any time): all outputs and internal state cleared.
  - code = 0, key = 0, valid_out = 0, pad_words = 0, blk_cnt = 0.
  - Word index = 0, state = IDLE, staging buffer = 0.
  - A partial block in progress is discarded; no valid_out.
- States:
  - IDLE: no partial block. The first accepted word latches key_in into key_stage, writes the staging word at index 0, sets idx = 1 and goes to FILL.
  - FILL: each accepted word writes staging[idx*WORD_W +: WORD_W] and increments idx. Word 0 occupies bits [31:0]; word 7 occupies [255:224].
  - Completion occurs when the accepted word has idx = WORDS-1 or in_last = 1, whichever comes first.
- On completion, at the same clock edge:
  - code <= staging with the just-accepted word merged in and all higher words forced to 0.
  - key <= key_stage, or key_in if the completing word is also the first word.
  - pad_words <= WORDS-1-idx_of_completing_word.
  - blk_cnt <= blk_cnt+1, with modulo-2^16 wrap.
  - valid_out <= 1 for exactly that following cycle.
  - Staging buffer cleared, idx = 0, state = IDLE.
- Latency: valid_out rises on the cycle after the completing word's acceptance edge.
- Throughput: back-to-back blocks with no bubble.
  - A new block's first word may be accepted in the cycle right after completion, so valid_out may be high on consecutive cycles only if consecutive words each complete a block (single-word last messages).
- key_in changes during FILL are ignored until the next block's first word.
- in_last on word 8 gives a normal full block with pad_words = 0. No empty block is ever emitted.
- code, key and pad_words hold their values between strobes; valid_out = 0 outside strobes.
- in_valid with en low is ignored; in_last on an unaccepted beat has no effect.

Test Plan:
- Reset, then 8 words 0x00000001..0x00000008 with key_in=0x5A, in_last=0 throughout:
  - one valid_out pulse the cycle after word 8.
  - code = 0x00000008_00000007_..._00000001, key=0x5A, pad_words=0, blk_cnt=1.
- 3 words 0xAAAA0000, 0xBBBB1111, 0xCCCC2222, in_last on the 3rd:
  - code[95:0] = 0xCCCC2222_BBBB1111_AAAA0000, code[255:96] = 0, pad_words=5.
- key_in=0x11 at word 1, changed to 0x22 at word 4 of the same block:
  - emitted key = 0x11.
  - next block started with key_in=0x22 emits key = 0x22.
- 16 consecutive words with in_valid held high, then a single word with in_last:
  - valid_out pulses after words 8 and 16, then one cycle after word 17.
  - Third block has pad_words=7; blk_cnt ends at 3; in_ready never drops while en=1.
- 5 words accepted, then en low for 4 cycles with in_valid high, then en high and 3 more words:
  - no words accepted while en low.
  - one block with words in original order, pad_words=0.
- 4 words accepted, then rst_n pulsed low mid-cycle:
  - all outputs 0 immediately (async); no valid_out.
  - the next 8 words form a clean block with blk_cnt=1.
